// File: rtl/bitop_pkg.sv
// -----------------------------------------------------------------------------
// bitop_pkg
//   Shared definitions for the bitop arbiter slice: opcode encodings, the
//   controller state type and the clogb2 width helper.
// -----------------------------------------------------------------------------
package bitop_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Number of bits needed to hold 'value' (never less than 1).
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned bits;
      v    = value;
      bits = 0;
      while (v > 0) begin
         bits = bits + 1;
         v    = v >> 1;
      end
      if (bits == 0) bits = 1;
      return bits;
   endfunction

endpackage

// File: rtl/bitop_rr_arb.sv
// -----------------------------------------------------------------------------
// bitop_rr_arb
//   Combinational round-robin picker. Searches req starting at ptr, wrapping
//   from NUM_REQ-1 back to 0, and reports the first set bit.
// Ports
//   req         in   NUM_REQ  request vector
//   ptr         in   ID_W     index where the search starts
//   grant       out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx   out  ID_W     index of the granted requester
//   grant_valid out  1        at least one request present
// -----------------------------------------------------------------------------
module bitop_rr_arb
   import bitop_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]           req,
   input  logic [clogb2(NUM_REQ-1)-1:0] ptr,
   output logic [NUM_REQ-1:0]           grant,
   output logic [clogb2(NUM_REQ-1)-1:0] grant_idx,
   output logic                         grant_valid
);

   localparam int unsigned ID_W = clogb2(NUM_REQ-1);

   always_comb begin
      int unsigned      cand;
      logic [ID_W-1:0]  cand_idx;
      cand        = 0;
      cand_idx    = '0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand     = (32'(ptr) + i) % NUM_REQ;
         cand_idx = cand[ID_W-1:0];
         if (!grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bitop_arbiter.sv
// -----------------------------------------------------------------------------
// bitop_arbiter
//   Shares one WIDTH-bit bitwise unit (AND/OR/XOR/XNOR) between NUM_REQ
//   requesters. Round-robin grant, one operation in flight, fixed LATENCY
//   from accept edge to rsp_valid, result held until rsp_ready.
// Ports
//   clock      in   1              rising-edge clock
//   reset_n    in   1              asynchronous active-low reset
//   req_valid  in   NUM_REQ        per-requester request
//   req_ready  out  NUM_REQ        one-hot accept, only in IDLE
//   req_op     in   2*NUM_REQ      opcode, [2i+1:2i] for requester i
//   req_a      in   WIDTH*NUM_REQ  operand A, [WIDTH*i +: WIDTH]
//   req_b      in   WIDTH*NUM_REQ  operand B, same slicing
//   rsp_valid  out  1              result valid, held until rsp_ready
//   rsp_ready  in   1              consumer accepts result
//   rsp_id     out  ID_W           owner of the result
//   rsp_data   out  WIDTH          result
//   busy       out  1              operation in EXEC or RESP
// -----------------------------------------------------------------------------
module bitop_arbiter
   import bitop_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LATENCY = 3
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [2*NUM_REQ-1:0]         req_op,
   input  logic [WIDTH*NUM_REQ-1:0]     req_a,
   input  logic [WIDTH*NUM_REQ-1:0]     req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [clogb2(NUM_REQ-1)-1:0] rsp_id,
   output logic [WIDTH-1:0]             rsp_data,
   output logic                         busy
);

   localparam int unsigned      ID_W     = clogb2(NUM_REQ-1);
   localparam int unsigned      CNT_W    = clogb2(LATENCY-1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY-1);

   state_t state, state_nxt;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_valid;
   logic [ID_W-1:0]    rr_ptr;

   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_a, sel_b;

   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [ID_W-1:0]    id_q;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   result;

   bitop_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req         (req_valid),
      .ptr         (rr_ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // One-hot AND-OR mux of the winner's request fields.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op = sel_op | req_op[2*i +: 2];
            sel_a  = sel_a  | req_a[WIDTH*i +: WIDTH];
            sel_b  = sel_b  | req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      result = '0;
      case (op_q)
         OP_AND:  result = a_q & b_q;
         OP_OR:   result = a_q | b_q;
         OP_XOR:  result = a_q ^ b_q;
         OP_XNOR: result = ~(a_q ^ b_q);
         default: result = '0;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = EXEC;
         EXEC:    if (cnt == '0)   state_nxt = RESP;
         RESP:    if (rsp_ready)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs; grant is also masked by reset so nothing is offered while held.
   always_comb begin
      req_ready = '0;
      if (reset_n && state == IDLE) req_ready = grant;
      busy = (state != IDLE);
   end

   // Operand capture, latency counter, result register and rr pointer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         cnt       <= '0;
         rr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  op_q   <= sel_op;
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  id_q   <= grant_idx;
                  cnt    <= CNT_LOAD;
                  rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_data  <= result;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bitop_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bitop_arbiter
//   Directed scenarios plus randomized traffic. A cycle-level reference model
//   (accept time + latency, round-robin search over the valid vector) is
//   compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_bitop_arbiter;

   localparam int W = 16;
   localparam int N = 4;
   localparam int L = 3;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_op;
   logic [W*N-1:0]   req_a;
   logic [W*N-1:0]   req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [W-1:0]     rsp_data;
   logic             busy;

   always #5 clock = ~clock;

   bitop_arbiter #(
      .WIDTH   (W),
      .NUM_REQ (N),
      .LATENCY (L)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int tb_cyc   = 0;

   always @(posedge clock) tb_cyc = tb_cyc + 1;

   logic [1:0]   op_v [N];
   logic [W-1:0] a_v  [N];
   logic [W-1:0] b_v  [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cyc);
      end
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         req_op[2*i +: 2] = op_v[i];
         req_a[W*i +: W]  = a_v[i];
         req_b[W*i +: W]  = b_v[i];
      end
   endtask

   task automatic new_operands(input int i);
      op_v[i] = 2'($urandom_range(0, 3));
      a_v[i]  = 16'($urandom);
      b_v[i]  = 16'($urandom);
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   bit           m_active;
   int           m_ready_cyc;
   int           m_rr;
   logic [1:0]   m_id;
   logic [W-1:0] m_data;
   logic [N-1:0] exp_ready;
   int           win;
   bit           exp_rv;

   always @(negedge clock) begin
      if (!reset_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_busy",      busy, 0);
         chk("rst_rsp_id",    rsp_id, 0);
         chk("rst_rsp_data",  rsp_data, 0);
         m_active = 0;
         m_rr     = 0;
      end else begin
         win = -1;
         if (!m_active) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
         end
         exp_ready = '0;
         if (win >= 0) exp_ready[win] = 1'b1;
         exp_rv = m_active && (tb_cyc >= m_ready_cyc);
         chk("req_ready", req_ready, exp_ready);
         chk("rsp_valid", rsp_valid, exp_rv);
         chk("busy",      busy, m_active);
         if (exp_rv) begin
            chk("rsp_id",   rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
         end
         // advance to the state after the coming rising edge
         if (win >= 0) begin
            m_active    = 1;
            m_ready_cyc = tb_cyc + 1 + L;
            m_id        = 2'(win);
            m_data      = ref_op(op_v[win], a_v[win], b_v[win]);
            m_rr        = (win + 1) % N;
         end else if (exp_rv && rsp_ready) begin
            m_active = 0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic wait_grant(output int idx, output int at_cyc);
      idx    = -1;
      at_cyc = -1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clock);
         if (req_ready != '0) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
            at_cyc = tb_cyc;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready expected a grant within 60 cycles");
   endtask

   task automatic wait_rsp(output int at_cyc);
      at_cyc = -1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clock);
         if (rsp_valid) begin
            at_cyc = tb_cyc;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 60 cycles");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [W-1:0] exp_t2 [4];
   int           exp_rr [5];
   int           g, gc, prev_gc, rc;
   logic [W-1:0] snap_data;
   logic [1:0]   snap_id;
   logic [N-1:0] rdy;

   initial begin
      exp_t2 = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hF00F};
      exp_rr = '{0, 1, 2, 3, 0};

      // 1: reset held with every requester valid
      reset_n   = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) new_operands(i);
      drive_bus();
      repeat (3) @(negedge clock);
      chk("t1_req_ready", req_ready, 0);
      chk("t1_rsp_valid", rsp_valid, 0);
      chk("t1_busy",      busy, 0);
      step();
      reset_n   = 1'b1;
      req_valid = '0;

      // 2: each opcode on fixed operands from requester 0
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         op_v[0] = k[1:0];
         a_v[0]  = 16'h00FF;
         b_v[0]  = 16'h0F0F;
         drive_bus();
         req_valid = 4'b0001;
         wait_grant(g, gc);
         chk("t2_grant", g, 0);
         step();
         req_valid = '0;
         wait_rsp(rc);
         chk("t2_latency", rc - (gc + 1), 3);
         chk("t2_data",    rsp_data, exp_t2[k]);
         chk("t2_id",      rsp_id, 0);
         step();
      end

      // 3: all valid -> 0,1,2,3,0, accepts five cycles apart
      do_reset();
      req_valid = '1;
      prev_gc   = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(g, gc);
         chk("t3_order", g, exp_rr[k]);
         if (k > 0) chk("t3_spacing", gc - prev_gc, 5);
         prev_gc = gc;
         step();
         if (g >= 0) new_operands(g);
         drive_bus();
      end

      // 5: after grant 3 only requesters 1 and 3 -> 1 wins
      do_reset();
      req_valid = '1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, gc);
         chk("t5_order", g, k);
         step();
         if (g >= 0) new_operands(g);
         drive_bus();
      end
      req_valid = 4'b1010;
      wait_grant(g, gc);
      chk("t5_wrap", g, 1);
      step();

      // 4: back-pressure for 10 cycles while others wait
      req_valid = '1;
      rsp_ready = 1'b0;
      new_operands(1);
      drive_bus();
      wait_rsp(rc);
      snap_data = rsp_data;
      snap_id   = rsp_id;
      chk("t4_id", snap_id, 1);
      for (int t = 0; t < 10; t++) begin
         @(negedge clock);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_data",  rsp_data, snap_data);
         chk("t4_hold_id",    rsp_id, snap_id);
         chk("t4_no_grant",   req_ready, 0);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("t4_still_resp", rsp_valid, 1);
      @(negedge clock);
      chk("t4_regrant", req_ready, 4'b0100);
      chk("t4_cleared", rsp_valid, 0);

      // 6: reset during EXEC
      step();
      step();
      reset_n = 1'b0;
      #1;
      chk("t6_busy",      busy, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_req_ready", req_ready, 0);
      chk("t6_rsp_data",  rsp_data, 0);
      chk("t6_rsp_id",    rsp_id, 0);
      step();
      step();
      reset_n = 1'b1;
      wait_grant(g, gc);
      chk("t6_first_grant", g, 0);
      chk("t6_no_stale",    rsp_valid, 0);
      step();

      // randomized traffic, protocol-respecting requesters
      do_reset();
      req_valid = '0;
      for (int t = 0; t < 800; t++) begin
         @(negedge clock);
         rdy = req_ready;
         @(posedge clock);
         #1;
         for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               new_operands(i);
            end else if (!req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 3) == 0);
               new_operands(i);
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         drive_bus();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
